// File: rtl/sign_extension.sv
// rtl/sign_extension.sv - RV32I immediate generator (I/S/B/U/J) with optional output register
//
// Purpose:
//   Decode-stage immediate generator. Selects the immediate format from
//   opcode_i, rebuilds the immediate from the scattered fields of inst_i and
//   sign-extends it from inst_i[31]. imm_valid_o flags the opcodes that
//   carry an immediate; all other opcodes produce zero with the flag low.
//
// Configuration macro:
//   SIGN_EXT_REG_OUT_EN - when defined, both outputs are registered on
//   clk_i (1-cycle latency, asynchronous active-low reset to zero). When
//   undefined, the outputs are purely combinational and clk_i / rst_ni
//   are not used.
//
// Ports:
//   clk_i                 in   1           core clock (registered build only)
//   rst_ni                in   1           async active-low reset (registered build only)
//   inst_i                in   INST_WIDTH  raw instruction word
//   opcode_i              in   OPCODE      decoded major opcode, taken as given
//   immediate_extended_o  out  DATA_WIDTH  sign-extended immediate
//   imm_valid_o           out  1           opcode carries an immediate

module sign_extension #(
    parameter int INST_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int OPCODE     = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic [OPCODE-1:0]     opcode_i,
    output logic [DATA_WIDTH-1:0] immediate_extended_o,
    output logic                  imm_valid_o
);

    // Major opcode encodings
    localparam logic [OPCODE-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE-1:0] OP_ALUI   = 7'b0010011;
    localparam logic [OPCODE-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE-1:0] OP_ALU    = 7'b0110011;
    localparam logic [OPCODE-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE-1:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    imm_fmt_e              fmt;
    logic                  sign;
    logic [DATA_WIDTH-1:0] imm_i_fmt;
    logic [DATA_WIDTH-1:0] imm_s_fmt;
    logic [DATA_WIDTH-1:0] imm_b_fmt;
    logic [DATA_WIDTH-1:0] imm_u_fmt;
    logic [DATA_WIDTH-1:0] imm_j_fmt;
    logic [DATA_WIDTH-1:0] imm_d;
    logic                  imm_valid_d;

    // Format select. OP_ALU, SYSTEM, FENCE and illegal opcodes fall to NONE.
    always_comb begin
        fmt = FMT_NONE;
        case (opcode_i)
            OP_ALUI, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                  fmt = FMT_S;
            OP_BRANCH:                 fmt = FMT_B;
            OP_LUI, OP_AUIPC:          fmt = FMT_U;
            OP_JAL:                    fmt = FMT_J;
            OP_ALU:                    fmt = FMT_NONE;
            default:                   fmt = FMT_NONE;
        endcase
    end

    // The sign always comes from inst[31], whatever the format.
    assign sign = inst_i[31];

    // Shift-immediates are deliberately not special-cased: funct7 lands in
    // bits [11:5] and the ALU ignores the upper shamt bits.
    assign imm_i_fmt = {{20{sign}}, inst_i[31:20]};
    assign imm_s_fmt = {{20{sign}}, inst_i[31:25], inst_i[11:7]};
    // B and J offsets are in half-words, so bit 0 is always zero.
    assign imm_b_fmt = {{19{sign}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
    assign imm_u_fmt = {inst_i[31:12], 12'h000};
    assign imm_j_fmt = {{11{sign}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};

    always_comb begin
        imm_d       = '0;
        imm_valid_d = 1'b0;
        case (fmt)
            FMT_I: begin
                imm_d       = imm_i_fmt;
                imm_valid_d = 1'b1;
            end
            FMT_S: begin
                imm_d       = imm_s_fmt;
                imm_valid_d = 1'b1;
            end
            FMT_B: begin
                imm_d       = imm_b_fmt;
                imm_valid_d = 1'b1;
            end
            FMT_U: begin
                imm_d       = imm_u_fmt;
                imm_valid_d = 1'b1;
            end
            FMT_J: begin
                imm_d       = imm_j_fmt;
                imm_valid_d = 1'b1;
            end
            default: begin
                imm_d       = '0;
                imm_valid_d = 1'b0;
            end
        endcase
    end

`ifdef SIGN_EXT_REG_OUT_EN
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  imm_valid_q;

    // Async clear only; release waits for a real clock edge before the
    // first capture, so a mid-cycle deassert cannot load a glitch value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imm_q       <= '0;
            imm_valid_q <= 1'b0;
        end else begin
            imm_q       <= imm_d;
            imm_valid_q <= imm_valid_d;
        end
    end

    assign immediate_extended_o = imm_q;
    assign imm_valid_o          = imm_valid_q;

    // The opcode field of the word is ignored; opcode_i is authoritative.
    logic unused_inst_opcode;
    assign unused_inst_opcode = ^inst_i[6:0];
`else
    assign immediate_extended_o = imm_d;
    assign imm_valid_o          = imm_valid_d;

    // Clock and reset have no function in the combinational build.
    logic unused_clk_rst_opcode;
    assign unused_clk_rst_opcode = clk_i ^ rst_ni ^ (^inst_i[6:0]);
`endif

endmodule

// File: tb/tb_sign_extension.sv
// tb/tb_sign_extension.sv - self-checking bench for sign_extension (both build variants)

module tb_sign_extension;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] inst_i;
    logic [6:0]  opcode_i;
    logic [31:0] immediate_extended_o;
    logic        imm_valid_o;

    int checks;
    int errors;

    sign_extension dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .inst_i              (inst_i),
        .opcode_i            (opcode_i),
        .immediate_extended_o(immediate_extended_o),
        .imm_valid_o         (imm_valid_o)
    );

    initial clk_i = 1'b0;
    always #20 clk_i = ~clk_i;

    // Reference model: rebuild the immediate as a signed number from its
    // weighted fields, then take the low 32 bits of the two's complement.
    function automatic void ref_imm(input logic [31:0] inst, input logic [6:0] op,
                                    output logic [31:0] imm, output logic valid);
        longint v;
        v     = 0;
        valid = 1'b1;
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                v = longint'(inst[31:20]);
                if (inst[31]) v = v - 4096;
            end
            7'b0100011: begin
                v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
                if (inst[31]) v = v - 4096;
            end
            7'b1100011: begin
                v = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                  + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                if (inst[31]) v = v - 8192;
            end
            7'b0110111, 7'b0010111: begin
                v = longint'(inst[31:12]) * 4096;
            end
            7'b1101111: begin
                v = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
                  + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                if (inst[31]) v = v - 2097152;
            end
            default: begin
                v     = 0;
                valid = 1'b0;
            end
        endcase
        imm = v[31:0];
    endfunction

    task automatic test_reset();
        logic [31:0] e_imm;
        logic        e_val;
        // Inputs are zero with opcode 0: both builds must show 0 / 0.
        #5;
        checks++;
        if (immediate_extended_o !== 32'h0 || imm_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got imm=%h valid=%b, expected imm=00000000 valid=0",
                     immediate_extended_o, imm_valid_o);
        end
        // Clock runs with a valid input while reset is held.
        inst_i   = 32'h0050_0293;
        opcode_i = 7'b0010011;
        @(negedge clk_i);
        @(negedge clk_i);
        ref_imm(inst_i, opcode_i, e_imm, e_val);
`ifdef SIGN_EXT_REG_OUT_EN
        e_imm = 32'h0;
        e_val = 1'b0;
`endif
        checks++;
        if (immediate_extended_o !== e_imm || imm_valid_o !== e_val) begin
            errors++;
            $display("FAIL reset_hold: got imm=%h valid=%b, expected imm=%h valid=%b",
                     immediate_extended_o, imm_valid_o, e_imm, e_val);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] v_inst [12];
        logic [6:0]  v_op   [12];
        logic [31:0] v_imm  [12];
        logic        v_val  [12];
        v_inst[0]  = 32'h8000_0000; v_op[0]  = 7'b0010011; v_imm[0]  = 32'hFFFF_F800; v_val[0]  = 1'b1;
        v_inst[1]  = 32'h0050_0293; v_op[1]  = 7'b0010011; v_imm[1]  = 32'h0000_0005; v_val[1]  = 1'b1;
        v_inst[2]  = 32'h1010_0000; v_op[2]  = 7'b0000011; v_imm[2]  = 32'h0000_0101; v_val[2]  = 1'b1;
        v_inst[3]  = 32'h00C0_0167; v_op[3]  = 7'b1100111; v_imm[3]  = 32'h0000_000C; v_val[3]  = 1'b1;
        v_inst[4]  = 32'h80F8_0023; v_op[4]  = 7'b0100011; v_imm[4]  = 32'hFFFF_F800; v_val[4]  = 1'b1;
        v_inst[5]  = 32'h00F8_0023; v_op[5]  = 7'b0100011; v_imm[5]  = 32'h0000_0000; v_val[5]  = 1'b1;
        v_inst[6]  = 32'h0001_70B7; v_op[6]  = 7'b0110111; v_imm[6]  = 32'h0001_7000; v_val[6]  = 1'b1;
        v_inst[7]  = 32'h0001_70B7; v_op[7]  = 7'b0010111; v_imm[7]  = 32'h0001_7000; v_val[7]  = 1'b1;
        v_inst[8]  = 32'h0E80_026F; v_op[8]  = 7'b1101111; v_imm[8]  = 32'h0000_00E8; v_val[8]  = 1'b1;
        v_inst[9]  = 32'hF19F_F26F; v_op[9]  = 7'b1101111; v_imm[9]  = 32'hFFFF_FF18; v_val[9]  = 1'b1;
        v_inst[10] = 32'hFE41_04E3; v_op[10] = 7'b1100011; v_imm[10] = 32'hFFFF_FFE8; v_val[10] = 1'b1;
        v_inst[11] = 32'hFFFF_FFB3; v_op[11] = 7'b0110011; v_imm[11] = 32'h0000_0000; v_val[11] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            inst_i   = v_inst[i];
            opcode_i = v_op[i];
            @(negedge clk_i);
            checks++;
            if (immediate_extended_o !== v_imm[i] || imm_valid_o !== v_val[i]) begin
                errors++;
                $display("FAIL directed_%0d: inst=%h op=%b got imm=%h valid=%b, expected imm=%h valid=%b",
                         i, v_inst[i], v_op[i], immediate_extended_o, imm_valid_o, v_imm[i], v_val[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [12];
        logic [31:0] e_imm;
        logic        e_val;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b0110011, 7'b1110011, 7'b0001111, 7'b0000000};
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            inst_i = $urandom;
            if ($urandom_range(0, 3) == 0) opcode_i = 7'($urandom);
            else                           opcode_i = ops[$urandom_range(0, 11)];
            ref_imm(inst_i, opcode_i, e_imm, e_val);
            @(negedge clk_i);
            checks++;
            if (immediate_extended_o !== e_imm || imm_valid_o !== e_val) begin
                errors++;
                $display("FAIL random_%0d: inst=%h op=%b got imm=%h valid=%b, expected imm=%h valid=%b",
                         i, inst_i, opcode_i, immediate_extended_o, imm_valid_o, e_imm, e_val);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e_imm;
        logic        e_val;
        logic [6:0]  ops [9];
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
        @(negedge clk_i);
        inst_i   = $urandom;
        opcode_i = ops[0];
        for (int i = 0; i < 40; i++) begin
            ref_imm(inst_i, opcode_i, e_imm, e_val);
            @(negedge clk_i);
            checks++;
            if (immediate_extended_o !== e_imm || imm_valid_o !== e_val) begin
                errors++;
                $display("FAIL back_to_back_%0d: got imm=%h valid=%b, expected imm=%h valid=%b",
                         i, immediate_extended_o, imm_valid_o, e_imm, e_val);
            end
            inst_i   = $urandom;
            opcode_i = ops[(i + 1) % 9];
        end
    endtask

    task automatic test_mid_cycle_input();
        logic [31:0] a_imm, b_imm, e_imm;
        logic        a_val, b_val, e_val;
        @(negedge clk_i);
        inst_i   = 32'h0050_0293;
        opcode_i = 7'b0010011;
        ref_imm(inst_i, opcode_i, a_imm, a_val);
        @(negedge clk_i);
        inst_i   = 32'hF19F_F26F;
        opcode_i = 7'b1101111;
        ref_imm(inst_i, opcode_i, b_imm, b_val);
        #5;
`ifdef SIGN_EXT_REG_OUT_EN
        e_imm = a_imm;
        e_val = a_val;
`else
        e_imm = b_imm;
        e_val = b_val;
`endif
        checks++;
        if (immediate_extended_o !== e_imm || imm_valid_o !== e_val) begin
            errors++;
            $display("FAIL mid_cycle_input: got imm=%h valid=%b, expected imm=%h valid=%b",
                     immediate_extended_o, imm_valid_o, e_imm, e_val);
        end
        @(negedge clk_i);
        checks++;
        if (immediate_extended_o !== b_imm || imm_valid_o !== b_val) begin
            errors++;
            $display("FAIL mid_cycle_next_edge: got imm=%h valid=%b, expected imm=%h valid=%b",
                     immediate_extended_o, imm_valid_o, b_imm, b_val);
        end
    endtask

    task automatic test_reset_mid_cycle();
        logic [31:0] x_imm, e_imm;
        logic        x_val, e_val;
        @(negedge clk_i);
        inst_i   = 32'h8000_0000;
        opcode_i = 7'b0010011;
        ref_imm(inst_i, opcode_i, x_imm, x_val);
        @(negedge clk_i);
        checks++;
        if (immediate_extended_o !== x_imm || imm_valid_o !== x_val) begin
            errors++;
            $display("FAIL pre_reset_value: got imm=%h valid=%b, expected imm=%h valid=%b",
                     immediate_extended_o, imm_valid_o, x_imm, x_val);
        end
        #5 rst_ni = 1'b0;
        #1;
`ifdef SIGN_EXT_REG_OUT_EN
        e_imm = 32'h0;
        e_val = 1'b0;
`else
        e_imm = x_imm;
        e_val = x_val;
`endif
        checks++;
        if (immediate_extended_o !== e_imm || imm_valid_o !== e_val) begin
            errors++;
            $display("FAIL async_reset_assert: got imm=%h valid=%b, expected imm=%h valid=%b",
                     immediate_extended_o, imm_valid_o, e_imm, e_val);
        end
        #4 rst_ni = 1'b1;
        #1;
        checks++;
        if (immediate_extended_o !== e_imm || imm_valid_o !== e_val) begin
            errors++;
            $display("FAIL reset_release_no_capture: got imm=%h valid=%b, expected imm=%h valid=%b",
                     immediate_extended_o, imm_valid_o, e_imm, e_val);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (immediate_extended_o !== x_imm || imm_valid_o !== x_val) begin
            errors++;
            $display("FAIL post_reset_capture: got imm=%h valid=%b, expected imm=%h valid=%b",
                     immediate_extended_o, imm_valid_o, x_imm, x_val);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_ni   = 1'b0;
        inst_i   = 32'h0;
        opcode_i = 7'h0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_cycle_input();
        test_reset_mid_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_extension.md
# sign_extension

Immediate generator for the RV32I core's decode stage. It decodes the 7-bit major opcode and the 32-bit instruction word and produces the 32-bit sign-extended immediate in I, S, B, U or J format. A flag marks whether the opcode carries an immediate. The result feeds the ALU operand mux, the address adders and the branch/jump target logic.

## Interface
Parameters (values from `pkg_config`):
- `INST_WIDTH`, 32, instruction word width.
- `DATA_WIDTH`, 32, datapath / immediate width.
- `OPCODE`, 7, opcode field width.

Ports:
- `clk_i`  in  1  core clock; used only when the output register is compiled in.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `inst_i`  in  INST_WIDTH  raw instruction word.
- `opcode_i`  in  OPCODE  decoded major opcode; normally equals `inst_i[6:0]`, but is taken as given.
- `immediate_extended_o`  out  DATA_WIDTH  sign-extended immediate.
- `imm_valid_o`  out  1  high when `opcode_i` is one of the immediate-carrying opcodes listed below.

## Operation
The immediate format is selected by `opcode_i`. Opcode encodings are the `pkg_config` constants.

- I-type, for `OP_ALUI` (0010011), `OP_LOAD` (0000011) and `OP_JALR` (1100111): `{{20{inst[31]}}, inst[31:20]}`.
  - Shift-immediates are not special-cased; funct7 bits pass through in bits [11:5].
- S-type, for `OP_STORE` (0100011): `{{20{inst[31]}}, inst[31:25], inst[11:7]}`.
- B-type, for `OP_BRANCH` (1100011): `{{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`.
- U-type, for `OP_LUI` (0110111) and `OP_AUIPC` (0010111): `{inst[31:12], 12'h000}`.
- J-type, for `OP_JAL` (1101111): `{{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}`.
- Any other opcode (`OP_ALU`, SYSTEM, FENCE, illegal): immediate = 32'h0000_0000 and `imm_valid_o` = 0.
- For all listed opcodes `imm_valid_o` = 1.
- The sign bit is always `inst_i[31]`. No other instruction field affects the result.
- The decode is a pure function of (`inst_i`, `opcode_i`) and holds no internal state apart from the optional output register.

## Timing
- Default build (macro undefined):
  - Fully combinational, zero latency.
  - The output is valid within the same cycle once the inputs are stable.
  - `clk_i` and `rst_ni` are ignored.
- Registered build (macro defined):
  - Both outputs are registered on the rising edge of `clk_i`, giving 1 cycle of latency.
  - While `rst_ni` = 0: `immediate_extended_o` = 32'h0 and `imm_valid_o` = 0, asynchronously, regardless of the clock.
  - The first capture happens on the first rising edge after `rst_ni` deasserts.
  - Deasserting `rst_ni` mid-cycle does not produce a glitch capture; the register only updates on an edge.
  - Input changes between edges are not visible until the next edge.
  - Back-to-back distinct instructions produce back-to-back results, with no bubbles.

## Configuration
- Macro: `SIGN_EXT_REG_OUT_EN`.
- Defined: the output register described under Timing is instantiated, with 1-cycle latency and asynchronous active-low reset to zero.
- Undefined: outputs are driven combinationally and the clock and reset ports are left unconnected internally.
- Decode results are identical in both builds; only the latency differs.

## Test plan
Drive the inputs, then check after one 40 ns clock period; this check timing is valid for both builds.

- I-type:
  - `inst` 32'h8000_0000, `OP_ALUI` -> 32'hFFFF_F800, valid 1.
  - `inst` 32'h0050_0293, `OP_ALUI` -> 32'h0000_0005.
  - `inst` 32'h1010_0000, `OP_LOAD` -> 32'h0000_0101.
  - `inst` 32'h00C0_0167, `OP_JALR` -> 32'h0000_000C.
- S-type:
  - `inst` 32'h80F8_0023, `OP_STORE` -> 32'hFFFF_F800.
  - `inst` 32'h00F8_0023, `OP_STORE` -> 32'h0000_0000.
- U-type: `inst` 32'h0001_70B7, with both `OP_LUI` and `OP_AUIPC` -> 32'h0001_7000.
- J/B-type:
  - `inst` 32'h0E80_026F, `OP_JAL` -> 32'h0000_00E8.
  - `inst` 32'hF19F_F26F, `OP_JAL` -> 32'hFFFF_FF18.
  - `inst` 32'hFE41_04E3, `OP_BRANCH` -> 32'hFFFF_FFE8.
- No-immediate opcode: `inst` 32'hFFFF_FFB3, `OP_ALU` -> 32'h0000_0000, valid 0.
- Reset (registered build):
  - Drive a valid I-type input, then pull `rst_ni` low mid-cycle -> outputs go to 0 immediately.
  - Release `rst_ni` -> the correct immediate appears after the next rising edge, not before.
